// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state type, default sizes and the saturating-increment helper for mem_port_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DACC   = 2'd2
    } arb_state_e;

    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;
    localparam int CW_DEF      = 32;
    localparam int TIMEOUT_DEF = 255;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v == lim) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/arb_wdog.sv
// arb_wdog: per-transfer wait counter and sticky bus-error flag, built only with MEM_ARB_TIMEOUT_EN.
module arb_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic busy_i,
    input  logic ack_i,
    output logic abort_o,
    output logic bus_err_o
);

    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          bus_err_q, bus_err_d;

    // The count returns to zero whenever a transfer ends, so every grant starts from zero.
    always_comb begin
        abort_o   = busy_i & !ack_i & (wcnt_q == WW'(TIMEOUT));
        wcnt_d    = (!busy_i | ack_i | abort_o) ? '0 : wcnt_q + WW'(1);
        bus_err_d = bus_err_q | abort_o;
        bus_err_o = bus_err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch (read) and memory stage (read/write).
// Define MEM_ARB_TIMEOUT_EN to abort transfers that wait TIMEOUT cycles for MemAck and flag BusErr.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int CW      = CW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          IReqF,
    input  logic [AW-1:0] IAdrF,
    output logic [DW-1:0] IRdF,
    output logic          IStallF,
    input  logic          DReqM,
    input  logic          DWeM,
    input  logic [AW-1:0] DAdrM,
    input  logic [DW-1:0] DWdM,
    output logic [DW-1:0] DRdM,
    output logic          DStallM,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAdr,
    output logic [DW-1:0] MemWd,
    input  logic [DW-1:0] MemRd,
    input  logic          MemAck,
    output logic [CW-1:0] IStallCnt,
    output logic [CW-1:0] DStallCnt,
    output logic          BusErr
);

    arb_state_e    state_q, state_d;
    logic          last_d_q, last_d_d;
    logic [CW-1:0] icnt_q, icnt_d, dcnt_q, dcnt_d;
    logic          busy, done, abort, fetch_first, i_own, d_own;

`ifdef MEM_ARB_TIMEOUT_EN
    arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .busy_i   (busy),
        .ack_i    (MemAck),
        .abort_o  (abort),
        .bus_err_o(BusErr)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign abort          = 1'b0;
    assign BusErr         = 1'b0;
`endif

    always_comb begin
        i_own       = state_q == IFETCH;
        d_own       = state_q == DACC;
        busy        = i_own | d_own;
        done        = busy & (MemAck | abort);
        last_d_d    = (busy & MemAck) ? d_own : last_d_q;
        // Right after a data transfer the fetch goes first so it cannot starve.
        fetch_first = busy & MemAck & last_d_d;
        state_d     = !((state_q == IDLE) | done) ? state_q :
                      abort                       ? IDLE :
                      fetch_first                 ? (IReqF ? IFETCH : IDLE) :
                      DReqM                       ? DACC :
                      IReqF                       ? IFETCH : IDLE;
        MemReq      = busy;
        MemWe       = d_own & DWeM;
        MemAdr      = d_own ? DAdrM : i_own ? IAdrF : '0;
        MemWd       = d_own ? DWdM : '0;
        IStallF     = IReqF & !(i_own & (MemAck | abort));
        DStallM     = DReqM & !(d_own & (MemAck | abort));
        IRdF        = (i_own & MemAck & IReqF) ? MemRd : '0;
        DRdM        = (d_own & MemAck & DReqM) ? MemRd : '0;
        icnt_d      = IStallF ? CW'(sat_inc(64'(icnt_q), CW)) : icnt_q;
        dcnt_d      = DStallM ? CW'(sat_inc(64'(dcnt_q), CW)) : dcnt_q;
        IStallCnt   = icnt_q;
        DStallCnt   = dcnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            icnt_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            icnt_q   <= icnt_d;
            dcnt_q   <= dcnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level port model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 6;
    localparam int TO = 4;
    localparam int MAXC = (1 << CW) - 1;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          IReqF, IStallF, DReqM, DWeM, DStallM, MemReq, MemWe, MemAck, BusErr;
    logic [AW-1:0] IAdrF, DAdrM, MemAdr;
    logic [DW-1:0] IRdF, DWdM, DRdM, MemWd, MemRd;
    logic [CW-1:0] IStallCnt, DStallCnt;
    int            n_tests = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .CW(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .IReqF(IReqF), .IAdrF(IAdrF), .IRdF(IRdF), .IStallF(IStallF),
        .DReqM(DReqM), .DWeM(DWeM), .DAdrM(DAdrM), .DWdM(DWdM), .DRdM(DRdM), .DStallM(DStallM),
        .MemReq(MemReq), .MemWe(MemWe), .MemAdr(MemAdr), .MemWd(MemWd), .MemRd(MemRd), .MemAck(MemAck),
        .IStallCnt(IStallCnt), .DStallCnt(DStallCnt), .BusErr(BusErr)
    );

    task automatic idle_inputs();
        IReqF = 0; IAdrF = '0; DReqM = 0; DWeM = 0; DAdrM = '0; DWdM = '0; MemAck = 0; MemRd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        IReqF = 1;
        DReqM = 1;
        #2;
        n_tests++;
        if ({MemReq, MemWe, IStallF, DStallM} !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_ctrl: MemReq/MemWe/IStallF/DStallM=%b expected 0011", {MemReq, MemWe, IStallF, DStallM});
        end
        n_tests++;
        if ({IStallCnt, DStallCnt, BusErr} !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: IStallCnt=%0d DStallCnt=%0d BusErr=%b expected 0 0 0", IStallCnt, DStallCnt, BusErr);
        end
    endtask

    task automatic test_fetch();
        do_reset();
        IReqF = 1; IAdrF = 32'h100;
        @(negedge clk);
        n_tests++;
        if ({MemReq, IStallF} !== 2'b01) begin
            n_fail++;
            $display("FAIL fetch_c0: MemReq/IStallF=%b expected 01", {MemReq, IStallF});
        end
        tick();
        @(negedge clk);
        n_tests++;
        if ({MemReq, IStallF, MemWe, MemAdr, IRdF} !== {1'b1, 1'b1, 1'b0, 32'h100, 32'h0}) begin
            n_fail++;
            $display("FAIL fetch_c1: MemReq=%b IStallF=%b MemWe=%b MemAdr=%h IRdF=%h expected 1 1 0 00000100 0", MemReq, IStallF, MemWe, MemAdr, IRdF);
        end
        tick();
        MemAck = 1; MemRd = 32'hE3A01005;
        @(negedge clk);
        n_tests++;
        if ({MemReq, IStallF, IRdF} !== {1'b1, 1'b0, 32'hE3A01005}) begin
            n_fail++;
            $display("FAIL fetch_c2: MemReq=%b IStallF=%b IRdF=%h expected 1 0 e3a01005", MemReq, IStallF, IRdF);
        end
        tick();
        MemAck = 0; IReqF = 0;
        n_tests++;
        if (IStallCnt !== CW'(2)) begin
            n_fail++;
            $display("FAIL fetch_cnt: IStallCnt=%0d expected 2", IStallCnt);
        end
    endtask

    task automatic test_priority();
        do_reset();
        IReqF = 1; IAdrF = 32'h200; DReqM = 1; DWeM = 1; DAdrM = 32'h40; DWdM = 32'hDEADBEEF;
        @(negedge clk);
        n_tests++;
        if ({MemReq, IStallF, DStallM} !== 3'b011) begin
            n_fail++;
            $display("FAIL prio_c0: MemReq/IStallF/DStallM=%b expected 011", {MemReq, IStallF, DStallM});
        end
        tick();
        @(negedge clk);
        n_tests++;
        if ({MemReq, MemWe, MemAdr, MemWd} !== {1'b1, 1'b1, 32'h40, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL prio_dacc: MemReq=%b MemWe=%b MemAdr=%h MemWd=%h expected 1 1 00000040 deadbeef", MemReq, MemWe, MemAdr, MemWd);
        end
        tick();
        MemAck = 1;
        @(negedge clk);
        n_tests++;
        if ({IStallF, DStallM} !== 2'b10) begin
            n_fail++;
            $display("FAIL prio_ack: IStallF/DStallM=%b expected 10", {IStallF, DStallM});
        end
        tick();
        MemAck = 0; DReqM = 0;
        @(negedge clk);
        n_tests++;
        if ({MemReq, MemWe, MemAdr, MemWd} !== {1'b1, 1'b0, 32'h200, 32'h0}) begin
            n_fail++;
            $display("FAIL prio_ifetch: MemReq=%b MemWe=%b MemAdr=%h MemWd=%h expected 1 0 00000200 0", MemReq, MemWe, MemAdr, MemWd);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] adr;
        do_reset();
        IReqF = 1; IAdrF = 32'h100;
        tick();
        for (int k = 0; k < 4; k++) begin
            adr = (k < 2) ? 32'h100 : 32'h104;
            IAdrF = adr;
            MemAck = k[0];
            MemRd = 32'hA000 + k;
            @(negedge clk);
            n_tests++;
            if ({MemReq, IStallF, MemAdr} !== {1'b1, !k[0], adr}) begin
                n_fail++;
                $display("FAIL b2b_%0d: MemReq=%b IStallF=%b MemAdr=%h expected 1 %b %h", k, MemReq, IStallF, MemAdr, !k[0], adr);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        DReqM = 1; DWeM = 1; DAdrM = 32'h40; DWdM = 32'h1;
        tick();
        @(negedge clk);
        n_tests++;
        if ({MemReq, DStallCnt} !== {1'b1, CW'(1)}) begin
            n_fail++;
            $display("FAIL rstmid_pre: MemReq=%b DStallCnt=%0d expected 1 1", MemReq, DStallCnt);
        end
        #1 reset = 0;
        #1;
        n_tests++;
        if ({MemReq, MemWe, DStallM, IStallCnt, DStallCnt} !== {1'b0, 1'b0, 1'b1, CW'(0), CW'(0)}) begin
            n_fail++;
            $display("FAIL rstmid_async: MemReq=%b MemWe=%b DStallM=%b IStallCnt=%0d DStallCnt=%0d expected 0 0 1 0 0", MemReq, MemWe, DStallM, IStallCnt, DStallCnt);
        end
        DReqM = 0;
        #1 reset = 1;
        tick();
        n_tests++;
        if (MemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle: MemReq=%b expected 0", MemReq);
        end
    endtask

    task automatic test_flush();
        do_reset();
        DReqM = 1; DAdrM = 32'h80;
        tick();
        tick();
        DReqM = 0;
        @(negedge clk);
        n_tests++;
        if ({MemReq, DStallM} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_drop: MemReq/DStallM=%b expected 10", {MemReq, DStallM});
        end
        tick();
        MemAck = 1; MemRd = 32'h1234;
        @(negedge clk);
        n_tests++;
        if ({MemReq, DStallM, DRdM} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL flush_ack: MemReq=%b DStallM=%b DRdM=%h expected 1 0 0", MemReq, DStallM, DRdM);
        end
        tick();
        MemAck = 0;
        n_tests++;
        if (MemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: MemReq=%b expected 0", MemReq);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        DReqM = 1; DAdrM = 32'h80;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if ({DStallM, BusErr} !== 2'b10) begin
                n_fail++;
                $display("FAIL to_wait_%0d: DStallM/BusErr=%b expected 10", c, {DStallM, BusErr});
            end
            tick();
        end
        MemRd = 32'h5555;
        @(negedge clk);
        n_tests++;
        if ({DStallM, DRdM} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL to_abort: DStallM=%b DRdM=%h expected 0 0", DStallM, DRdM);
        end
        tick();
        n_tests++;
        if ({MemReq, BusErr, DStallM} !== 3'b011) begin
            n_fail++;
            $display("FAIL to_idle: MemReq/BusErr/DStallM=%b expected 011", {MemReq, BusErr, DStallM});
        end
        DReqM = 0;
        repeat (4) tick();
        n_tests++;
        if (BusErr !== 1'b1) begin
            n_fail++;
            $display("FAIL to_sticky: BusErr=%b expected 1", BusErr);
        end
`else
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_tests++;
            if ({DStallM, BusErr} !== 2'b10) begin
                n_fail++;
                $display("FAIL nto_wait_%0d: DStallM/BusErr=%b expected 10", c, {DStallM, BusErr});
            end
            tick();
        end
`endif
    endtask

    // Port owner model: 0 free, 1 fetch, 2 data; wt counts cycles the current transfer has waited.
    task automatic test_random();
        int            own, wt, ic, dc;
        bit            be, pi, pd, ab, ai, ad, e_is, e_ds;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_wd, e_ird, e_drd;
        do_reset();
        own = 0; wt = 0; ic = 0; dc = 0; be = 0; pi = 0; pd = 0;
        for (int c = 0; c < 400; c++) begin
            if (pi) IReqF = ($urandom_range(0, 9) != 0);
            else begin
                IReqF = $urandom_range(0, 1);
                IAdrF = $urandom;
            end
            if (pd) DReqM = ($urandom_range(0, 9) != 0);
            else begin
                DReqM = ($urandom_range(0, 2) == 0);
                DWeM = $urandom_range(0, 1);
                DAdrM = $urandom;
                DWdM = $urandom;
            end
            MemAck = ($urandom_range(0, 2) == 0);
            MemRd = $urandom;
            @(negedge clk);
            ai = (own == 1) && MemAck;
            ad = (own == 2) && MemAck;
            ab = TO_EN && (own != 0) && !MemAck && (wt == TO);
            e_is = IReqF && !((own == 1) && (MemAck || ab));
            e_ds = DReqM && !((own == 2) && (MemAck || ab));
            e_adr = (own == 2) ? DAdrM : (own == 1) ? IAdrF : '0;
            e_wd = (own == 2) ? DWdM : '0;
            e_ird = (ai && IReqF) ? MemRd : '0;
            e_drd = (ad && DReqM) ? MemRd : '0;
            n_tests++;
            if ({IStallF, DStallM, MemReq, MemWe} !== {e_is, e_ds, own != 0, (own == 2) && DWeM}) begin
                n_fail++;
                $display("FAIL rnd_ctrl c%0d: IStallF/DStallM/MemReq/MemWe=%b expected %b", c, {IStallF, DStallM, MemReq, MemWe}, {e_is, e_ds, own != 0, (own == 2) && DWeM});
            end
            n_tests++;
            if ({MemAdr, MemWd} !== {e_adr, e_wd}) begin
                n_fail++;
                $display("FAIL rnd_bus c%0d: MemAdr=%h MemWd=%h expected %h %h", c, MemAdr, MemWd, e_adr, e_wd);
            end
            n_tests++;
            if ({IRdF, DRdM} !== {e_ird, e_drd}) begin
                n_fail++;
                $display("FAIL rnd_rdata c%0d: IRdF=%h DRdM=%h expected %h %h", c, IRdF, DRdM, e_ird, e_drd);
            end
            n_tests++;
            if ({IStallCnt, DStallCnt, BusErr} !== {CW'(ic), CW'(dc), be}) begin
                n_fail++;
                $display("FAIL rnd_cnt c%0d: IStallCnt=%0d DStallCnt=%0d BusErr=%b expected %0d %0d %b", c, IStallCnt, DStallCnt, BusErr, ic, dc, be);
            end
            ic = (e_is && ic < MAXC) ? ic + 1 : ic;
            dc = (e_ds && dc < MAXC) ? dc + 1 : dc;
            wt = (own != 0 && !MemAck && !ab) ? wt + 1 : 0;
            if (own == 0) own = DReqM ? 2 : IReqF ? 1 : 0;
            else if (MemAck) own = (own == 2) ? (IReqF ? 1 : 0) : (DReqM ? 2 : IReqF ? 1 : 0);
            else if (ab) begin
                own = 0;
                be = 1;
            end
            pi = e_is;
            pd = e_ds;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        test_flush();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
